// File: rtl/waveform_sample_buffer.sv
`default_nettype none
// ============================================================================
// Module   : waveform_sample_buffer
// Brief    : Circular ECG sample store replayed per pixel column, with optional
//            decimation and a per-frame pointer snapshot to avoid tearing.
// Revision : 1.0 - initial release
// ============================================================================
module waveform_sample_buffer #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10,
    parameter int DECIM  = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic signed [8:0]   sample_in,
    input  logic                sample_valid,
    input  logic                freeze,
    input  logic                clear,
    input  logic        [10:0]  hcount,
    input  logic        [9:0]   vcount,
    output logic signed [8:0]   signal_out,
    output logic                full,
    output logic [ADDR_W:0]     fill_level
);

    localparam logic [ADDR_W:0] c_DEPTH_CNT  = (ADDR_W+1)'(DEPTH);
    localparam logic [7:0]      c_DECIM_LAST = 8'(DECIM - 1);

    logic signed [8:0]   r_mem [DEPTH];

    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [ADDR_W:0]     r_fill_count;
    logic [7:0]          r_decim_cnt;
    logic [ADDR_W-1:0]   r_frame_ptr;
    logic [ADDR_W:0]     r_frame_fill;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic                r_blank;
    logic signed [8:0]   r_signal_out;

    logic                w_accept;
    logic                w_store;
    logic                w_frame_start;
    logic [ADDR_W-1:0]   w_h_addr;
    logic [ADDR_W-1:0]   w_rd_addr;
    logic                w_blank;

    assign w_accept      = sample_valid && !freeze && !clear;
    assign w_store       = w_accept && (r_decim_cnt == c_DECIM_LAST);
    assign w_frame_start = (hcount == 11'd0) && (vcount == 10'd0);

    // A full buffer rotates so the oldest sample lands on column 0.
    assign w_h_addr  = ADDR_W'(hcount);
    assign w_rd_addr = (r_frame_fill == c_DEPTH_CNT) ? (r_frame_ptr + w_h_addr) : w_h_addr;
    assign w_blank   = (32'(hcount) >= 32'(r_frame_fill)) || (32'(hcount) >= 32'(DEPTH));

    // Read-first RAM: the output register below samples the pre-write contents.
    always_ff @(posedge clk) begin
        if (w_store) begin
            r_mem[r_wr_ptr] <= sample_in;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr     <= '0;
            r_fill_count <= '0;
            r_decim_cnt  <= '0;
            r_frame_ptr  <= '0;
            r_frame_fill <= '0;
            r_rd_addr    <= '0;
            // Starts blanked so unwritten RAM never reaches the screen.
            r_blank      <= 1'b1;
            r_signal_out <= '0;
        end else begin
            if (clear) begin
                r_wr_ptr     <= '0;
                r_fill_count <= '0;
                r_decim_cnt  <= '0;
            end else if (w_accept) begin
                if (w_store) begin
                    r_decim_cnt <= '0;
                    r_wr_ptr    <= r_wr_ptr + 1'b1;
                    if (r_fill_count != c_DEPTH_CNT) begin
                        r_fill_count <= r_fill_count + 1'b1;
                    end
                end else begin
                    r_decim_cnt <= r_decim_cnt + 8'd1;
                end
            end

            if (w_frame_start) begin
                r_frame_ptr  <= r_wr_ptr;
                r_frame_fill <= r_fill_count;
            end

            r_rd_addr    <= w_rd_addr;
            r_blank      <= w_blank;
            r_signal_out <= r_blank ? 9'sd0 : r_mem[r_rd_addr];
        end
    end

    assign signal_out = r_signal_out;
    assign full       = (r_fill_count == c_DEPTH_CNT);
    assign fill_level = r_fill_count;

endmodule
`default_nettype wire
